// File: rtl/psi_key_sequencer.sv
// Anubis-128 key-evolution sequencer: iterates the Psi round block once per
// accepted handshake and streams K^0 .. K^ROUNDS to the round-key consumer.
module psi_key_sequencer #(
   parameter int unsigned ROUNDS = 12
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic [127:0] data_in_i,
   output logic [4:0]   rc_index_o,
   input  logic [127:0] round_constants_i,
   output logic         key_valid_o,
   input  logic         key_ready_i,
   output logic [127:0] key_out_o,
   output logic [4:0]   key_index_o,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic {StIdle, StEmit} state_e;

   // Mini-boxes of the Anubis/Khazad S-box, nibble 0 in the top bits.
   localparam logic [63:0] PTab = 64'h3FE054BCDA967821;
   localparam logic [63:0] QTab = 64'h9E56A23CF04D7B18;
   localparam logic [4:0]  LastRound = 5'(ROUNDS);

   state_e         state_q, state_d;
   logic [127:0]   key_q, key_d;
   logic [4:0]     round_q, round_d;
   logic           done_q, done_d;
   logic [127:0]   psi_out;

   function automatic logic [3:0] mini_p(input logic [3:0] x);
      return PTab[(15 - int'(x)) * 4 +: 4];
   endfunction

   function automatic logic [3:0] mini_q(input logic [3:0] x);
      return QTab[(15 - int'(x)) * 4 +: 4];
   endfunction

   // Three P/Q layers with a two-bit cross exchange between layers.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [3:0] u, l, u2, l2;
      u  = mini_p(x[7:4]);
      l  = mini_q(x[3:0]);
      u2 = {u[3:2], l[3:2]};
      l2 = {u[1:0], l[1:0]};
      u  = mini_q(u2);
      l  = mini_p(l2);
      u2 = {u[3:2], l[3:2]};
      l2 = {u[1:0], l[1:0]};
      return {mini_p(u2), mini_q(l2)};
   endfunction

   // GF(2^8) doubling modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   // Multiply by the Hadamard coefficient h[sel], h = (01, 02, 04, 06).
   function automatic logic [7:0] hmul(input logic [7:0] a, input logic [1:0] sel);
      logic [7:0] x2, x4, r;
      x2 = xtime(a);
      x4 = xtime(x2);
      case (sel)
         2'd0:    r = a;
         2'd1:    r = x2;
         2'd2:    r = x4;
         default: r = x4 ^ x2;
      endcase
      return r;
   endfunction

   // Psi = sigma[c] o theta o pi o gamma on a 4x4 byte matrix, row-major, byte 0 in MSBs.
   function automatic logic [127:0] psi(input logic [127:0] k, input logic [127:0] c);
      logic [127:0] g, p, r;
      logic [7:0]   acc;
      for (int n = 0; n < 16; n++) begin
         g[127 - 8 * n -: 8] = sbox(k[127 - 8 * n -: 8]);
      end
      // Column j is rotated down by j rows.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            p[127 - 8 * (4 * i + j) -: 8] = g[127 - 8 * (4 * ((i - j + 4) % 4) + j) -: 8];
         end
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            acc = 8'h00;
            for (int m = 0; m < 4; m++) begin
               acc = acc ^ hmul(p[127 - 8 * (4 * i + m) -: 8], 2'(m ^ j));
            end
            r[127 - 8 * (4 * i + j) -: 8] = acc ^ c[127 - 8 * (4 * i + j) -: 8];
         end
      end
      return r;
   endfunction

   assign psi_out = psi(key_q, round_constants_i);

   // Next-state logic: abort dominates start and the handshake.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
      if (abort_i) begin
         state_d = StIdle;
         key_d   = '0;
         round_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d = StEmit;
                  key_d   = data_in_i;
                  round_d = '0;
               end
            end
            StEmit: begin
               if (key_ready_i) begin
                  if (round_q < LastRound) begin
                     key_d   = psi_out;
                     round_d = round_q + 5'd1;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State, key register, round counter and registered done pulse.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   // Outputs follow the registered state directly.
   always_comb begin
      key_valid_o = (state_q == StEmit);
      busy_o      = (state_q == StEmit);
      key_out_o   = key_q;
      key_index_o = round_q;
      rc_index_o  = round_q + 5'd1;
      done_o      = done_q;
   end

endmodule

// File: tb/tb_psi_key_sequencer.sv
// Randomised and directed bench for psi_key_sequencer with a byte-matrix reference model.
module tb_psi_key_sequencer;

   localparam int unsigned R = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0, abort = 1'b0, key_ready = 1'b0;
   logic [127:0] data_in = '0;
   logic [4:0]   rc_index;
   logic [127:0] round_constants;
   logic         key_valid, busy, done;
   logic [127:0] key_out;
   logic [4:0]   key_index;

   logic         start_z = 1'b0;
   logic [4:0]   rc_index_z, key_index_z;
   logic         key_valid_z, busy_z, done_z;
   logic [127:0] key_out_z;

   logic [127:0] rom [32];
   int           n_cmp = 0, n_err = 0;

   bit           m_active, m_done;
   int           m_round;
   logic [127:0] m_key;

   always #5 clk = ~clk;

   assign round_constants = rom[rc_index];

   psi_key_sequencer #(.ROUNDS(R)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .abort_i(abort),
      .data_in_i(data_in), .rc_index_o(rc_index), .round_constants_i(round_constants),
      .key_valid_o(key_valid), .key_ready_i(key_ready), .key_out_o(key_out),
      .key_index_o(key_index), .busy_o(busy), .done_o(done)
   );

   psi_key_sequencer #(.ROUNDS(1)) dut_z (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start_z), .abort_i(1'b0),
      .data_in_i(128'h0), .rc_index_o(rc_index_z), .round_constants_i(128'h0),
      .key_valid_o(key_valid_z), .key_ready_i(1'b1), .key_out_o(key_out_z),
      .key_index_o(key_index_z), .busy_o(busy_z), .done_o(done_z)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) r = r ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
         b = b >> 1;
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [3:0] pt [16] = '{4'h3, 4'hF, 4'hE, 4'h0, 4'h5, 4'h4, 4'hB, 4'hC,
                              4'hD, 4'hA, 4'h9, 4'h6, 4'h7, 4'h8, 4'h2, 4'h1};
      logic [3:0] qt [16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                              4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};
      int hi, lo, a, b;
      hi = int'(pt[x[7:4]]);
      lo = int'(qt[x[3:0]]);
      for (int layer = 0; layer < 2; layer++) begin
         a  = (hi & 12) | (lo >> 2);
         b  = ((hi & 3) << 2) | (lo & 3);
         hi = int'(layer == 0 ? qt[a] : pt[a]);
         lo = int'(layer == 0 ? pt[b] : qt[b]);
      end
      return 8'((hi << 4) | lo);
   endfunction

   function automatic logic [127:0] psi_m(input logic [127:0] k, input logic [127:0] c);
      logic [7:0] a [4][4];
      logic [7:0] g [4][4];
      logic [7:0] p [4][4];
      logic [7:0] h [4] = '{8'h01, 8'h02, 8'h04, 8'h06};
      logic [7:0] t;
      logic [127:0] r = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            a[i][j] = k[127 - 8 * (4 * i + j) -: 8];
            g[i][j] = sbox_m(a[i][j]);
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) p[i][j] = g[(i - j + 4) % 4][j];
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            t = 8'h00;
            for (int m = 0; m < 4; m++) t = t ^ gmul(p[i][m], h[m ^ j]);
            r[127 - 8 * (4 * i + j) -: 8] = t ^ c[127 - 8 * (4 * i + j) -: 8];
         end
      return r;
   endfunction

   // Model of the schedule: position in the key sequence and the current key.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 0; m_done <= 0; m_round <= 0; m_key <= '0;
      end else begin
         m_done <= 0;
         if (abort) begin
            m_active <= 0; m_round <= 0; m_key <= '0;
         end else if (!m_active) begin
            if (start) begin
               m_active <= 1; m_round <= 0; m_key <= data_in;
            end
         end else if (key_ready) begin
            if (m_round < int'(R)) begin
               m_key   <= psi_m(m_key, rom[m_round + 1]);
               m_round <= m_round + 1;
            end else begin
               m_active <= 0; m_done <= 1;
            end
         end
      end
   end

   // Per-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      check("key_valid", 128'(key_valid), 128'(m_active));
      check("busy", 128'(busy), 128'(m_active));
      check("done", 128'(done), 128'(m_done));
      if (m_active) begin
         check("key_out", key_out, m_key);
         check("key_index", 128'(key_index), 128'(m_round));
         check("rc_index", 128'(rc_index), 128'(m_round + 1));
      end
      if (!rst_n) begin
         check("rst_key_out", key_out, 128'h0);
         check("rst_key_index", 128'(key_index), 128'h0);
         check("rst_rc_index", 128'(rc_index), 128'h1);
      end
   end

   task automatic pulse_start(input logic [127:0] d);
      data_in = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_index(input int idx, output bit found);
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (key_valid && int'(key_index) == idx) found = 1;
      end
   endtask

   initial begin
      int  nvalid, ndone, done_at, max_idx;
      bit  found, stalled, ignored;
      logic [127:0] d2;
      for (int i = 0; i < 32; i++) rom[i] = {$urandom, $urandom, $urandom, $urandom};
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      key_ready = 1'b1;
      @(negedge clk);

      // Full schedule with the consumer always ready.
      data_in = 128'h000102030405060708090A0B0C0D0E0F; start = 1'b1;
      nvalid = 0; ndone = 0; done_at = -1;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 0) begin
            check("t1_first_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);
            check("t1_first_index", 128'(key_index), 128'h0);
         end
         if (key_valid) nvalid++;
         if (done) begin ndone++; done_at = c + 1; end
      end
      check("t1_valid_cycles", 128'(nvalid), 128'd13);
      check("t1_done_count", 128'(ndone), 128'd1);
      check("t1_done_cycle", 128'(done_at), 128'd14);

      // Backpressure at index 4, ignored start at index 6.
      pulse_start({$urandom, $urandom, $urandom, $urandom});
      stalled = 0; ignored = 0; ndone = 0; max_idx = -1;
      for (int c = 0; c < 60; c++) begin
         if (key_valid && int'(key_index) > max_idx) max_idx = int'(key_index);
         if (done) ndone++;
         if (key_valid && key_index == 5'd4 && !stalled) begin
            stalled = 1; key_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("t2_stall_index", 128'(key_index), 128'd4);
               check("t2_stall_rc", 128'(rc_index), 128'd5);
               check("t2_stall_valid", 128'(key_valid), 128'd1);
            end
            key_ready = 1'b1;
            @(negedge clk);
            check("t2_resume_index", 128'(key_index), 128'd5);
         end else if (key_valid && key_index == 5'd6 && !ignored) begin
            ignored = 1; data_in = '1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      check("t2_max_index", 128'(max_idx), 128'd12);
      check("t2_done_count", 128'(ndone), 128'd1);
      check("t2_ignored_seen", 128'(ignored), 128'd1);

      // Abort at index 8.
      pulse_start({$urandom, $urandom, $urandom, $urandom});
      wait_index(8, found);
      check("t3_reach_idx8", 128'(found), 128'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t3_valid", 128'(key_valid), 128'd0);
      check("t3_busy", 128'(busy), 128'd0);
      check("t3_index", 128'(key_index), 128'd0);
      ndone = 0;
      for (int c = 0; c < 4; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("t3_no_done", 128'(ndone), 128'd0);
      d2 = {$urandom, $urandom, $urandom, $urandom};
      pulse_start(d2);
      check("t3_restart_key", key_out, d2);
      check("t3_restart_index", 128'(key_index), 128'd0);
      repeat (16) @(negedge clk);

      // Asynchronous reset mid-schedule at index 3.
      pulse_start({$urandom, $urandom, $urandom, $urandom});
      wait_index(3, found);
      check("t4_reach_idx3", 128'(found), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_valid", 128'(key_valid), 128'd0);
      check("t4_busy", 128'(busy), 128'd0);
      check("t4_done", 128'(done), 128'd0);
      check("t4_key_out", key_out, 128'h0);
      check("t4_index", 128'(key_index), 128'd0);
      check("t4_rc", 128'(rc_index), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0; nvalid = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (key_valid) nvalid++;
      end
      check("t4_idle_after", 128'(nvalid), 128'd0);
      check("t4_no_done", 128'(ndone), 128'd0);

      // Randomised traffic: random backpressure, occasional start/abort.
      for (int c = 0; c < 600; c++) begin
         key_ready = ($urandom_range(0, 3) != 0);
         start     = ($urandom_range(0, 4) == 0);
         abort     = ($urandom_range(0, 60) == 0);
         data_in   = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; key_ready = 1'b1;
      repeat (20) @(negedge clk);

      // Zero vector on the single-round instance.
      start_z = 1'b1;
      @(negedge clk);
      start_z = 1'b0;
      check("t6_k0", key_out_z, 128'h0);
      check("t6_k0_valid", 128'(key_valid_z), 128'd1);
      @(negedge clk);
      check("t6_k1_literal", key_out_z, {16{8'hBA}});
      check("t6_k1_model", key_out_z, psi_m(128'h0, 128'h0));
      check("t6_k1_index", 128'(key_index_z), 128'd1);
      @(negedge clk);
      check("t6_done", 128'(done_z), 128'd1);
      check("t6_idle", 128'(busy_z), 128'd0);
      @(negedge clk);
      check("t6_done_single", 128'(done_z), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/psi_key_sequencer.md
# psi_key_sequencer

Sequential controller that iterates the combinational Psi round block (Gamma → Pi → Theta → round-constant add) to produce the evolving 128-bit Anubis key states K^0 … K^ROUNDS, one per handshake. It owns the 128-bit key-state register and the round counter. It requests each round constant from an external constant ROM by index, and streams key states to the round-key extraction stage under a valid/ready handshake. It sits between key loading and the cipher datapath's round-key consumer.

## Interface
- ROUNDS, 12, number of Psi iterations. Produces ROUNDS+1 key states. Legal range 1..31.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a schedule; sampled only in IDLE.
- abort  in  1  synchronous; returns to IDLE from any state without asserting done.
- data_in  in  128  initial key state K^0; sampled when start is accepted.
- rc_index  out  5  index of the round constant needed for the next Psi step; always round+1.
- round_constants  in  128  constant c^(rc_index) from the external ROM; must be valid combinationally in the same cycle.
- key_valid  out  1  key_out/key_index hold a valid key state.
- key_ready  in  1  consumer accepts the key state when it is high together with key_valid.
- key_out  out  128  current key state K^key_index.
- key_index  out  5  round number r of key_out.
- busy  out  1  high in EMIT.
- done  out  1  one-cycle pulse, registered, after the final key state is accepted.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - busy=0, key_valid=0.
  - start=1 (and abort=0): state_reg←data_in, round←0, go to EMIT.
- EMIT:
  - busy=1, key_valid=1, key_out=state_reg, key_index=round.
  - Handshake (key_valid & key_ready) with round<ROUNDS: state_reg←Psi(state_reg, round_constants), round←round+1. Stay in EMIT.
  - Handshake with round==ROUNDS: go to IDLE; done=1 on the next cycle.
  - No handshake: state_reg, round, key_out and key_index hold.
- abort=1 in any state: go to IDLE next cycle. state_reg and round are cleared to 0. No done pulse. abort has priority over start and over the handshake.
- start while in EMIT is ignored; it is neither queued nor does it restart the schedule.
- Psi is instantiated once and evaluated combinationally from state_reg and round_constants. There is no iteration inside a single cycle.
- round is a 5-bit counter with no wrap. Range checking relies on the ROUNDS parameter limit.

## Timing
- Reset (reset_n=0), applied asynchronously:
  - state IDLE, state_reg=0, round=0.
  - key_valid=0, busy=0, done=0, key_out=0, key_index=0, rc_index=1.
- Reset asserted mid-schedule aborts immediately. No done pulse is produced.
- Start accepted at edge T: key_valid=1 and key_out=data_in from cycle T+1.
- With key_ready held high, a new key state is presented every cycle.
- Total latency: ROUNDS+1 valid cycles. Final handshake at cycle T+ROUNDS+1; done pulses in cycle T+ROUNDS+2 with busy=0.
- Back-to-back schedules: start may be asserted in the same cycle as the done pulse, since the block is already in IDLE. key_valid then reasserts on the next cycle.
- round_constants is sampled only at a handshake edge in which round<ROUNDS. At all other times it is don't-care.

## Test plan
- ROUNDS=12, key_ready=1, data_in=128'h000102…0F, start pulsed at cycle 0:
  - key_valid high in cycles 1–13, key_index 0..12.
  - Cycle 1 key_out = 128'h000102…0F.
  - rc_index 1..13 in step with key_index.
  - done single pulse in cycle 14.
  - All 13 key_out values match the software Anubis-128 key evolution model.
- Backpressure: hold key_ready=0 for 3 cycles when key_index=4.
  - key_out, key_index=4 and rc_index=5 stay stable.
  - key_valid stays 1.
  - The sequence resumes with key_index=5 one cycle after key_ready rises, with no skipped or duplicated index.
- Ignored start: assert start with data_in=all-ones while key_index=6.
  - The schedule continues unaffected and still ends with key_index=12.
  - Exactly one done pulse.
- Abort: abort=1 when key_index=8.
  - Next cycle: key_valid=0, busy=0, key_index=0, no done pulse.
  - A new start then yields key_out=new data_in at key_index 0.
- Reset mid-operation: reset_n=0 for 1 cycle at key_index=3.
  - All outputs return to reset values immediately, with rc_index=1.
  - No done pulse.
  - After release, the block stays idle until start.
- Zero vector: data_in=0, ROUNDS=1, constant ROM returns 0.
  - key_out K^0=0; K^1 equals Psi(0,0) from the reference model.
  - done in cycle 3 after start at cycle 0.
